// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus word-wide memory port of the load/store unit.
// master = processor/memory side, slave = mem_access_unit.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: one request at a time, sub-word loads extended, sub-word stores
// done as read-modify-write because the data memory has no byte enables.
module mem_access_unit (
    input logic              clk,
    input logic              rst,
    mem_access_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, LCAP, DONE} stateT;

    stateT       state, nextState;
    logic        outOfReset, accept, sizeErr;
    logic        opWrite, opUnsigned, opErr;
    logic [1:0]  opSize, opLane;
    logic [15:0] opWdata;
    logic [31:0] memAddr, memWdata, rspRdata;
    logic [4:0]  laneShift;
    logic [31:0] laneData, loadExt, laneMask, laneIns, merged;

    // Ready waits for the first edge after reset release, not just rst going high.
    assign bus.req_ready = (state == IDLE) && outOfReset;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        sizeErr = 1'b1;
        case (bus.req_size)
            2'b00:   sizeErr = 1'b0;
            2'b01:   sizeErr = bus.req_addr[0];
            2'b10:   sizeErr = |bus.req_addr[1:0];
            default: sizeErr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (accept) begin
                if (sizeErr)                                     nextState = DONE;
                else if (bus.req_write && bus.req_size == 2'b10) nextState = WRITE;
                else                                             nextState = READ;
            end
            READ:    nextState = opWrite ? MERGE : LCAP;
            MERGE:   nextState = WRITE;
            WRITE:   nextState = DONE;
            LCAP:    nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Lane extraction and merge work off the latched byte offset only.
    assign laneShift = {opLane, 3'b000};
    assign laneData  = bus.mem_rdata >> laneShift;

    always_comb begin
        loadExt  = laneData;
        laneMask = 32'hFFFF_FFFF;
        laneIns  = 32'h0;
        case (opSize)
            2'b00: begin
                loadExt  = {{24{laneData[7] & ~opUnsigned}}, laneData[7:0]};
                laneMask = 32'h0000_00FF << laneShift;
                laneIns  = {24'h0, opWdata[7:0]} << laneShift;
            end
            2'b01: begin
                loadExt  = {{16{laneData[15] & ~opUnsigned}}, laneData[15:0]};
                laneMask = 32'h0000_FFFF << laneShift;
                laneIns  = {16'h0, opWdata} << laneShift;
            end
            default: ;
        endcase
    end

    assign merged = (bus.mem_rdata & ~laneMask) | laneIns;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outOfReset <= 1'b0;
            opWrite    <= 1'b0;
            opUnsigned <= 1'b0;
            opErr      <= 1'b0;
            opSize     <= 2'b00;
            opLane     <= 2'b00;
            opWdata    <= 16'h0;
            memAddr    <= 32'h0;
            memWdata   <= 32'h0;
            rspRdata   <= 32'h0;
        end else begin
            outOfReset <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    opWrite    <= bus.req_write;
                    opUnsigned <= bus.req_unsigned;
                    opErr      <= sizeErr;
                    opSize     <= bus.req_size;
                    opLane     <= bus.req_addr[1:0];
                    opWdata    <= bus.req_wdata[15:0];
                    // Errors never touch the memory port, so its address is left alone.
                    if (sizeErr) begin
                        rspRdata <= 32'h0;
                    end else begin
                        memAddr <= {bus.req_addr[31:2], 2'b00};
                        if (bus.req_write && bus.req_size == 2'b10) memWdata <= bus.req_wdata;
                    end
                end
                MERGE:   memWdata <= merged;
                LCAP:    rspRdata <= loadExt;
                WRITE:   rspRdata <= 32'h0;
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.mem_we    = (state == WRITE);
    assign bus.rsp_valid = (state == DONE);
    assign bus.rsp_err   = (state == DONE) && opErr;
    assign bus.rsp_rdata = rspRdata;
endmodule
